// File: rtl/sdram_bist_sequencer_if.sv
// sdram_bist_sequencer_if
// Conduit bundle between the BIST sequencer and the qsys SDRAM write/read
// masters.
//   master modport : sequencer side (programs lengths/bases, issues go pulses,
//                    pushes write data, pops read data)
//   slave modport  : qsys master side (done/full/available flags, read data)
// Signals:
//   wr_fixed_location, wr_base, wr_length, wr_go : write-master programming
//   wr_write_buffer, wr_data                     : write FIFO push strobe/data
//   wr_done, wr_buffer_full                      : write-master status
//   rd_fixed_location, rd_base, rd_length, rd_go : read-master programming
//   rd_read_buffer                               : read FIFO pop strobe
//   rd_data, rd_data_available                   : show-ahead read data/valid
//   rd_done, rd_early_done                       : read-master status
interface sdram_bist_sequencer_if;
    logic        wr_fixed_location;
    logic [31:0] wr_base;
    logic [31:0] wr_length;
    logic        wr_go;
    logic        wr_done;
    logic        wr_write_buffer;
    logic [63:0] wr_data;
    logic        wr_buffer_full;

    logic        rd_fixed_location;
    logic [31:0] rd_base;
    logic [31:0] rd_length;
    logic        rd_go;
    logic        rd_done;
    logic        rd_early_done;
    logic        rd_read_buffer;
    logic [63:0] rd_data;
    logic        rd_data_available;

    modport master (
        output wr_fixed_location, wr_base, wr_length, wr_go,
        output wr_write_buffer, wr_data,
        input  wr_done, wr_buffer_full,
        output rd_fixed_location, rd_base, rd_length, rd_go,
        output rd_read_buffer,
        input  rd_done, rd_early_done, rd_data, rd_data_available
    );

    modport slave (
        input  wr_fixed_location, wr_base, wr_length, wr_go,
        input  wr_write_buffer, wr_data,
        output wr_done, wr_buffer_full,
        input  rd_fixed_location, rd_base, rd_length, rd_go,
        input  rd_read_buffer,
        output rd_done, rd_early_done, rd_data, rd_data_available
    );
endinterface

// File: rtl/sdram_bist_sequencer.sv
// sdram_bist_sequencer
// SDRAM built-in self-test: fills num_words 64-bit words from base_addr with
// seed+i through the qsys write master, reads the region back through the read
// master and compares every word against the regenerated pattern.
// Ports:
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   start                  : one-cycle run request (accepted in IDLE/DONE)
//   base_addr, num_words, seed : test parameters, latched on accepted start
//   busy, done, pass       : run status; pass valid while done is high
//   err_count              : saturating mismatch count
//   first_err_idx          : word index of the first mismatch (0 if none)
//   bus (master modport)   : conduits to the qsys write/read masters
module sdram_bist_sequencer #(
    parameter int unsigned NW_W = 24
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  start,
    input  logic [31:0]           base_addr,
    input  logic [NW_W-1:0]       num_words,
    input  logic [63:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [NW_W-1:0]       first_err_idx,
    sdram_bist_sequencer_if.master bus
);

    localparam logic [NW_W-1:0] NW_ONE = NW_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_GO,
        S_WR_FILL,
        S_WR_WAIT,
        S_RD_GO,
        S_RD_CHECK,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [NW_W-1:0] nw_q;
    logic [31:0]     base_q;
    logic [31:0]     len_q;
    logic [NW_W-1:0] wr_idx_q;
    logic [NW_W-1:0] rd_idx_q;
    logic [63:0]     wr_pat_q;
    logic [63:0]     rd_pat_q;

    logic            cmp_vld_q;
    logic [63:0]     cmp_data_q;
    logic [63:0]     cmp_exp_q;
    logic [NW_W-1:0] cmp_idx_q;

    logic [15:0]     err_q;
    logic [NW_W-1:0] ferr_q;
    logic            pass_q;
    logic            busy_q;
    logic            done_q;
    logic            wr_go_q;
    logic            rd_go_q;

    logic            start_acc;
    logic            push;
    logic            pop;
    logic            wr_last;
    logic            rd_last;
    logic            mismatch;
    logic            unused_inputs;

    assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign push      = (state_q == S_WR_FILL) && !bus.wr_buffer_full;
    assign pop       = (state_q == S_RD_CHECK) && bus.rd_data_available;
    assign wr_last   = (wr_idx_q == (nw_q - NW_ONE));
    assign rd_last   = (rd_idx_q == (nw_q - NW_ONE));
    assign mismatch  = cmp_vld_q && (cmp_data_q != cmp_exp_q);

    // Early-done and the dropped address LSBs carry no information here.
    assign unused_inputs = ^{bus.rd_early_done, base_addr[2:0]};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WR_GO;
                end
            end
            S_WR_GO: begin
                // Zero-length runs skip both masters entirely.
                state_d = (nw_q == '0) ? S_DONE : S_WR_FILL;
            end
            S_WR_FILL: begin
                if (push && wr_last) begin
                    state_d = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (bus.wr_done) begin
                    state_d = S_RD_GO;
                end
            end
            S_RD_GO: begin
                state_d = S_RD_CHECK;
            end
            S_RD_CHECK: begin
                if (pop && rd_last) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // The compare stage must be empty so pass sees the final count.
                if (bus.rd_done && !cmp_vld_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_go_q <= 1'b0;
            rd_go_q <= 1'b0;
        end else begin
            busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q  <= (state_d == S_DONE);
            // nw_q is loaded on this same edge, so qualify with the live input.
            wr_go_q <= start_acc && (num_words != '0);
            rd_go_q <= (state_d == S_RD_GO);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cmp_vld_q  <= 1'b0;
            cmp_data_q <= '0;
            cmp_exp_q  <= '0;
            cmp_idx_q  <= '0;
        end else begin
            cmp_vld_q <= pop;
            if (pop) begin
                cmp_data_q <= bus.rd_data;
                cmp_exp_q  <= rd_pat_q;
                cmp_idx_q  <= rd_idx_q;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            nw_q     <= '0;
            base_q   <= '0;
            len_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            wr_pat_q <= '0;
            rd_pat_q <= '0;
            err_q    <= '0;
            ferr_q   <= '0;
            pass_q   <= 1'b0;
        end else if (start_acc) begin
            nw_q     <= num_words;
            base_q   <= {base_addr[31:3], 3'b000};
            len_q    <= 32'(num_words) << 3;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            wr_pat_q <= seed;
            rd_pat_q <= seed;
            err_q    <= '0;
            ferr_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            // Pattern registers track seed+idx incrementally; indices stop at
            // num_words-1 while the pattern may step one past the region.
            if (push) begin
                wr_pat_q <= wr_pat_q + 64'd1;
                if (!wr_last) begin
                    wr_idx_q <= wr_idx_q + NW_ONE;
                end
            end
            if (pop) begin
                rd_pat_q <= rd_pat_q + 64'd1;
                if (!rd_last) begin
                    rd_idx_q <= rd_idx_q + NW_ONE;
                end
            end
            if (mismatch) begin
                if (err_q != 16'hFFFF) begin
                    err_q <= err_q + 16'd1;
                end
                if (err_q == '0) begin
                    ferr_q <= cmp_idx_q;
                end
            end
            if ((state_d == S_DONE) && (state_q != S_DONE)) begin
                pass_q <= (err_q == '0);
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = ferr_q;

    assign bus.wr_fixed_location = 1'b0;
    assign bus.wr_base           = base_q;
    assign bus.wr_length         = len_q;
    assign bus.wr_go             = wr_go_q;
    assign bus.wr_write_buffer   = push;
    assign bus.wr_data           = wr_pat_q;

    assign bus.rd_fixed_location = 1'b0;
    assign bus.rd_base           = base_q;
    assign bus.rd_length         = len_q;
    assign bus.rd_go             = rd_go_q;
    assign bus.rd_read_buffer    = pop;

endmodule
